// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;
   localparam int PC_W = 64;
   localparam int INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} fetch_state_t;
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetched {pc, instr} entries with flush.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic         full,
   output logic         empty,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);
   localparam int PW = $clog2(DEPTH);
   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;
   assign full    = cnt_q == CW'(DEPTH);
   assign empty   = cnt_q == '0;
   assign count   = cnt_q;
   assign head    = mem_q[rd_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   always_ff @(posedge clk)
      if (!reset || flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches from instruction memory and buffers {pc, instr} for decode.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          BUF_DEPTH = 2,
   parameter int          ADDR_W    = 64
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              MemRead,
   input  logic [31:0]       instr,
   input  logic              instr_valid,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [ADDR_W-1:0] if_pc,
   output logic [31:0]       if_instr,
   output logic              misalign_err
);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   fetch_state_t      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic              err_q, full, empty, push, pop, will_fill;
   logic [CW-1:0]     count;
   fetch_entry_t      din, head;
   assign mem_addr     = pc_q;
   assign MemRead      = state_q == S_FETCH && !full && !redirect_valid;
   assign push         = MemRead && instr_valid;
   assign pop          = if_valid && if_ready && !redirect_valid;
   assign will_fill    = !pop && (full || (push && count == CW'(BUF_DEPTH - 1)));
   assign din          = {PC_W'(pc_q), instr};
   assign if_valid     = !empty;
   assign if_pc        = head.pc[ADDR_W-1:0];
   assign if_instr     = if_valid ? head.instr : NOP_INSTR;
   assign misalign_err = err_q;
   fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (din),
      .full  (full),
      .empty (empty),
      .count (count),
      .head  (head)
   );
   // Redirect wins over everything: it flushes the buffer and restarts fetch at the aligned target.
   always_ff @(posedge clk)
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= ADDR_W'(RESET_PC);
         err_q   <= 1'b0;
      end else if (redirect_valid) begin
         state_q <= S_FETCH;
         pc_q    <= {redirect_pc[ADDR_W-1:2], 2'b00};
         err_q   <= err_q || redirect_pc[1:0] != 2'b00;
      end else begin
         if (push) pc_q <= pc_q + ADDR_W'(INSTR_BYTES);
         state_q <= state_q == S_IDLE ? S_FETCH :
                    state_q == S_HOLD ? (pop ? S_FETCH : S_HOLD) :
                    (will_fill ? S_HOLD : S_FETCH);
      end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed checks against a queue-based fetch model.
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] mem_addr;
   logic        MemRead;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        misalign_err;
   int          n_cmp = 0;
   int          n_err = 0;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;
   ent_t        q[$];
   logic [63:0] m_pc = '0;
   bit          m_run = 0;
   bit          m_err = 0;
   localparam int DEPTH = 2;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .MemRead(MemRead),
      .instr(instr), .instr_valid(instr_valid), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_instr(if_instr), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == 64'h0) return 32'h0050_0093;
      if (a == 64'h4) return 32'h0050_0113;
      return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("mem_addr", mem_addr, m_pc);
      chk("MemRead", 64'(MemRead), 64'(m_run && q.size() < DEPTH && !redirect_valid));
      chk("if_valid", 64'(if_valid), 64'(q.size() != 0));
      chk("misalign_err", 64'(misalign_err), 64'(m_err));
      if (q.size() != 0) begin
         chk("if_pc", if_pc, q[0].pc);
         chk("if_instr", 64'(if_instr), 64'(q[0].ins));
      end
   endtask

   task automatic model_update(input logic r, iv, rv, input logic [63:0] rpc, input logic rdy);
      bit mr = m_run && q.size() < DEPTH && !rv;
      if (!r) begin
         m_pc = '0; m_run = 0; m_err = 0; q.delete();
      end else if (rv) begin
         m_pc = {rpc[63:2], 2'b00}; q.delete(); m_run = 1;
         if (rpc[1:0] != 2'b00) m_err = 1;
      end else if (!m_run) begin
         m_run = 1;
      end else begin
         if (q.size() != 0 && rdy) void'(q.pop_front());
         if (mr && iv) begin
            q.push_back('{m_pc, mem_word(m_pc)});
            m_pc = m_pc + 64'd4;
         end
      end
   endtask

   task automatic step(input logic r, iv, rv, input logic [63:0] rpc, input logic rdy);
      @(negedge clk);
      reset = r; instr_valid = iv; redirect_valid = rv; redirect_pc = rpc; if_ready = rdy;
      instr = mem_word(mem_addr);
      #1 compare();
      @(posedge clk);
      model_update(r, iv, rv, rpc, rdy);
   endtask

   initial begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      #1;
      chk("lit_rst_addr", mem_addr, 64'h0);
      chk("lit_rst_memread", 64'(MemRead), 64'h0);
      chk("lit_rst_valid", 64'(if_valid), 64'h0);
      chk("lit_rst_err", 64'(misalign_err), 64'h0);
      step(1, 1, 0, 0, 1);
      #1;
      chk("lit_c1_memread", 64'(MemRead), 64'h1);
      chk("lit_c1_addr", mem_addr, 64'h0);
      step(1, 1, 0, 0, 1);
      #1;
      chk("lit_first_valid", 64'(if_valid), 64'h1);
      chk("lit_first_pc", if_pc, 64'h0);
      chk("lit_first_instr", 64'(if_instr), 64'h0050_0093);
      step(1, 1, 0, 0, 1);
      #1;
      chk("lit_second_pc", if_pc, 64'h4);
      chk("lit_second_instr", 64'(if_instr), 64'h0050_0113);

      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      #1;
      chk("lit_full_memread", 64'(MemRead), 64'h0);
      chk("lit_full_addr", mem_addr, 64'h8);
      chk("lit_full_head", if_pc, 64'h0);
      step(1, 1, 0, 0, 0);
      #1;
      chk("lit_hold_addr", mem_addr, 64'h8);
      step(1, 1, 0, 0, 1);
      #1;
      chk("lit_drain_pc4", if_pc, 64'h4);
      chk("lit_drain_memread", 64'(MemRead), 64'h1);
      step(1, 1, 0, 0, 1);
      #1;
      chk("lit_drain_pc8", if_pc, 64'h8);

      step(1, 1, 1, 64'h10, 1);
      repeat (3) step(1, 0, 0, 0, 1);
      #1;
      chk("lit_wait_addr", mem_addr, 64'h10);
      chk("lit_wait_memread", 64'(MemRead), 64'h1);
      chk("lit_wait_valid", 64'(if_valid), 64'h0);
      step(1, 1, 0, 0, 1);
      #1;
      chk("lit_wait_pc", if_pc, 64'h10);

      step(1, 1, 1, 64'h20, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      #1;
      chk("lit_pre_redir_pc", if_pc, 64'h20);
      step(1, 1, 1, 64'h8, 1);
      #1;
      chk("lit_redir_valid", 64'(if_valid), 64'h0);
      chk("lit_redir_addr", mem_addr, 64'h8);
      step(1, 1, 0, 0, 1);
      #1;
      chk("lit_redir_pc", if_pc, 64'h8);

      step(1, 0, 1, 64'h1E, 1);
      #1;
      chk("lit_mis_addr", mem_addr, 64'h1C);
      chk("lit_mis_err", 64'(misalign_err), 64'h1);
      step(1, 0, 1, 64'h40, 1);
      #1;
      chk("lit_mis_sticky", 64'(misalign_err), 64'h1);
      chk("lit_mis_addr2", mem_addr, 64'h40);

      repeat (3) step(1, 1, 0, 0, 0);
      #1;
      chk("lit_prerst_full", 64'(MemRead), 64'h0);
      step(0, 1, 0, 0, 0);
      #1;
      chk("lit_mid_rst_valid", 64'(if_valid), 64'h0);
      chk("lit_mid_rst_memread", 64'(MemRead), 64'h0);
      chk("lit_mid_rst_addr", mem_addr, 64'h0);
      chk("lit_mid_rst_err", 64'(misalign_err), 64'h0);

      for (int i = 0; i < 4000; i++) begin
         logic [63:0] rpc;
         rpc = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rpc[63:8] = '1;
         if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
         step($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 15) == 0, rpc, $urandom_range(0, 9) < 6);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Initiator side of the instruction-memory fetch interface. Owns the 64-bit PC and drives mem_addr/MemRead toward the instruction memory. Captures each returned instr together with its PC into a small FIFO. Presents {pc, instr} to decode over a valid/ready handshake and supports PC redirects from branch/jump resolution.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
BUF_DEPTH, 2, fetch-buffer entries; power of 2, minimum 2
ADDR_W, 64, PC/address width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
mem_addr  out  ADDR_W  fetch address (PC) to instruction memory
MemRead  out  1  fetch request / read enable to instruction memory
instr  in  32  instruction returned by memory
instr_valid  in  1  instr is valid this cycle
redirect_valid  in  1  load new PC, flush pending fetches
redirect_pc  in  ADDR_W  redirect target
if_valid  out  1  {if_pc, if_instr} valid to decode
if_ready  in  1  decode accepts the current entry
if_pc  out  ADDR_W  PC of the presented instruction
if_instr  out  32  presented instruction
misalign_err  out  1  sticky: a redirect_pc with [1:0] != 0 was received

Behaviour:
- Reset is sampled on clk while reset==0. It sets pc=RESET_PC, state=S_IDLE, clears the FIFO, and sets MemRead=0, if_valid=0, misalign_err=0. mem_addr shows RESET_PC.
- A reset in the middle of a fetch discards everything. No partial entry survives.
- mem_addr is the pc register itself, not a combinational function of inputs.
- FSM S_IDLE: one cycle after reset release, then go to S_FETCH. This gives the memory a settle cycle.
- FSM S_FETCH: MemRead = !full && !redirect_valid.
  - Accept occurs when MemRead && instr_valid in the same cycle.
  - On accept, push {pc, instr} and set pc += 4 (wraps modulo 2^ADDR_W).
  - MemRead && !instr_valid is a wait state: hold pc and hold MemRead. There is no timeout.
  - If full, go to S_HOLD.
- FSM S_HOLD: MemRead=0, pc held. Return to S_FETCH on the cycle after any pop.
- MemRead depends only on registered state/count and redirect_valid. There is no combinational path from if_ready.
- FIFO output: if_valid = !empty. if_pc/if_instr come from the head entry.
  - A pop occurs when if_valid && if_ready.
  - Push and pop in the same cycle (not full) leave count unchanged.
  - When full, a pop frees space only for the next cycle.
- Redirect has the highest priority, above push and pop.
  - pc is loaded with {redirect_pc[ADDR_W-1:2], 2'b00}.
  - The FIFO is flushed, so if_valid=0 next cycle.
  - An instr_valid arriving in the same cycle is discarded.
  - state goes to S_FETCH. Any pop in that cycle is also ignored.
- If redirect_pc[1:0] != 0, set misalign_err=1. It stays set until reset.
- Back-to-back redirects: the last one wins. No fetch occurs while redirect_valid is held.
- Throughput: with a zero-latency memory and if_ready=1, one instruction is delivered per cycle. The first if_valid appears 2 cycles after reset release.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum fetch_state_t {S_IDLE, S_FETCH, S_HOLD}
  - typedef struct fetch_entry_t {pc, instr}
  - constants INSTR_BYTES=4 and NOP_INSTR=32'h00000013
- Sub-module fetch_buffer: parameterised synchronous FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, count, head.
  - Its reset style matches the parent (synchronous, active-low).

Test Plan:
- Reset, then instr_mem loaded with mem[0]=00500093, mem[1]=00500113, if_ready=1 -> cycle 1 MemRead=1, mem_addr=0. Decode receives (0,00500093), then (4,00500113), one per cycle.
- if_ready=0 from reset -> FIFO fills with PCs 0 and 4. MemRead drops and mem_addr holds 8. Raising if_ready drains 0, 4, then fetches 8 with no instruction lost or duplicated.
- instr_valid held low 3 cycles at mem_addr=0x10 -> MemRead held, pc stays 0x10, if_valid=0 once the FIFO drains. The first instr_valid pushes (0x10, instr).
- FIFO holding PCs 0x20 and 0x24 plus redirect_valid with redirect_pc=0x8 -> next cycle if_valid=0 and mem_addr=0x8. The next delivered pc is 0x8, and the same-cycle instr is dropped.
- redirect_pc=0x1E -> pc=0x1C and misalign_err=1. misalign_err stays 1 after a later aligned redirect and clears only on reset.
- reset=0 asserted mid-stream with the FIFO full -> next cycle if_valid=0, MemRead=0, mem_addr=RESET_PC, misalign_err=0.
